// File: rtl/change_event_logger.sv
// rtl/change_event_logger.sv - change detector logging timestamped {old, new} records into a show-ahead FIFO
module change_event_logger #(
    parameter int WIDTH    = 8,
    parameter int TS_WIDTH = 16,
    parameter int DEPTH    = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                enable,
    input  logic [WIDTH-1:0]    sig,
    output logic                evt_valid,
    input  logic                evt_ready,
    output logic [WIDTH-1:0]    evt_old,
    output logic [WIDTH-1:0]    evt_new,
    output logic [TS_WIDTH-1:0] evt_time,
    output logic [WIDTH-1:0]    rise,
    output logic [WIDTH-1:0]    fall,
    output logic                overflow,
    output logic [15:0]         drop_count,
    input  logic                clear_overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]         FULL_COUNT = (AW+1)'(DEPTH);
    localparam logic [AW:0]         CNT_ONE    = 1;
    localparam logic [AW-1:0]       PTR_ONE    = 1;
    localparam logic [TS_WIDTH-1:0] TS_ONE     = 1;

    logic [TS_WIDTH-1:0] r_ts;
    logic [WIDTH-1:0]    r_prev;
    logic                r_armed;
    logic [WIDTH-1:0]    r_rise;
    logic [WIDTH-1:0]    r_fall;

    logic [WIDTH-1:0]    r_mem_old  [DEPTH];
    logic [WIDTH-1:0]    r_mem_new  [DEPTH];
    logic [TS_WIDTH-1:0] r_mem_time [DEPTH];
    logic [AW-1:0]       r_wr_ptr;
    logic [AW-1:0]       r_rd_ptr;
    logic [AW:0]         r_count;

    logic                r_overflow;
    logic [15:0]         r_drop_count;

    logic w_live;
    logic w_change;
    logic w_valid;
    logic w_pop;
    logic w_full;
    logic w_push;
    logic w_drop;

    // armed is only set after a primed enabled cycle, so the first sample never logs
    assign w_live   = enable & r_armed;
    assign w_change = w_live & (sig != r_prev);
    assign w_valid  = (r_count != '0);
    assign w_pop    = w_valid & evt_ready;
    assign w_full   = (r_count == FULL_COUNT);
    assign w_push   = w_change & (~w_full | w_pop);
    assign w_drop   = w_change & w_full & ~w_pop;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ts    <= '0;
            r_prev  <= '0;
            r_armed <= 1'b0;
            r_rise  <= '0;
            r_fall  <= '0;
        end else begin
            r_ts <= r_ts + TS_ONE;
            if (enable) begin
                r_prev  <= sig;
                r_armed <= 1'b1;
            end else begin
                r_armed <= 1'b0;
            end
            r_rise <= w_live ? (sig & ~r_prev) : '0;
            r_fall <= w_live ? (~sig & r_prev) : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && w_push) begin
            r_mem_old[r_wr_ptr]  <= r_prev;
            r_mem_new[r_wr_ptr]  <= sig;
            r_mem_time[r_wr_ptr] <= r_ts;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_ONE;
                2'b01:   r_count <= r_count - CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    // a drop coinciding with a clear restarts the count at one
    always_ff @(posedge clk) begin
        if (reset) begin
            r_overflow   <= 1'b0;
            r_drop_count <= '0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
            if (clear_overflow) begin
                r_drop_count <= 16'd1;
            end else if (r_drop_count != 16'hFFFF) begin
                r_drop_count <= r_drop_count + 16'd1;
            end
        end else if (clear_overflow) begin
            r_overflow   <= 1'b0;
            r_drop_count <= '0;
        end
    end

    assign evt_valid  = w_valid;
    assign evt_old    = w_valid ? r_mem_old[r_rd_ptr]  : '0;
    assign evt_new    = w_valid ? r_mem_new[r_rd_ptr]  : '0;
    assign evt_time   = w_valid ? r_mem_time[r_rd_ptr] : '0;
    assign rise       = r_rise;
    assign fall       = r_fall;
    assign overflow   = r_overflow;
    assign drop_count = r_drop_count;

endmodule
